// File: rtl/oam_dma_ctrl.sv
// oam_dma_ctrl: Game Boy OAM DMA sequencer copying LEN bytes from {page,8'h00} into OAM
module oam_dma_ctrl #(
    parameter int LEN         = 160,
    parameter int START_DELAY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_we,
    input  logic [7:0]  cpu_di,
    output logic [15:0] src_addr,
    output logic        src_re,
    input  logic [7:0]  src_data,
    output logic [7:0]  oam_addr,
    output logic [7:0]  oam_wdata,
    output logic        oam_we,
    output logic        busy,
    output logic        cpu_block,
    output logic [7:0]  dma_reg
);
    typedef enum logic [1:0] {IDLE, START, XFER, DRAIN} state_t;
    localparam logic [7:0] LAST  = 8'(LEN - 1);
    localparam logic [2:0] DELAY = 3'(START_DELAY);
    state_t      state_q;
    logic [2:0]  cnt_q;
    logic [7:0]  page_q, dma_reg_q, widx_q, page_d;
    logic [15:0] src_addr_q;
    logic        src_re_q, wv_q, trig;
    assign trig   = cpu_we && cpu_addr == 16'hFF46;
    // echo and OAM/IO pages fold back onto work RAM 0xC0-0xDF
    assign page_d = (cpu_di >= 8'hE0) ? cpu_di - 8'h20 : cpu_di;
    // sequencer: src_addr_q[7:0] doubles as the read index, wv_q/widx_q carry each read to its OAM write
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            page_q     <= '0;
            dma_reg_q  <= '0;
            src_addr_q <= '0;
            src_re_q   <= 1'b0;
            wv_q       <= 1'b0;
            widx_q     <= '0;
        end else if (trig) begin
            state_q   <= START;
            cnt_q     <= DELAY;
            page_q    <= page_d;
            dma_reg_q <= cpu_di;
            src_re_q  <= 1'b0;
            wv_q      <= 1'b0;
        end else begin
            wv_q   <= src_re_q;
            widx_q <= src_addr_q[7:0];
            case (state_q)
                START: begin
                    if (cnt_q <= 3'd1) begin
                        state_q    <= XFER;
                        src_re_q   <= 1'b1;
                        src_addr_q <= {page_q, 8'h00};
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                XFER: begin
                    if (src_addr_q[7:0] == LAST) begin
                        state_q  <= DRAIN;
                        src_re_q <= 1'b0;
                    end else begin
                        src_addr_q[7:0] <= src_addr_q[7:0] + 8'd1;
                    end
                end
                DRAIN:   state_q <= IDLE;
                default: state_q <= state_q;
            endcase
        end
    end
    assign src_addr  = src_addr_q;
    assign src_re    = src_re_q;
    // a trigger in the same cycle cancels the pending write, including the DRAIN byte
    assign oam_we    = wv_q && !trig;
    assign oam_addr  = widx_q;
    assign oam_wdata = wv_q ? src_data : 8'h00;
    assign busy      = state_q != IDLE;
    // HRAM stays reachable so the CPU can run its wait loop during the copy
    assign cpu_block = (state_q == XFER || state_q == DRAIN) && !(cpu_addr >= 16'hFF80 && cpu_addr <= 16'hFFFE);
    assign dma_reg   = dma_reg_q;
endmodule

// File: tb/tb_oam_dma_ctrl.sv
// tb_oam_dma_ctrl: directed vectors for oam_dma_ctrl at START_DELAY 1, 0 and 3 side by side
module tb_oam_dma_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] cpu_addr = '0;
    logic        cpu_we = 1'b0;
    logic [7:0]  cpu_di = '0;
    logic [15:0] src_addr_w [3];
    logic [7:0]  oam_addr_w [3];
    logic [7:0]  oam_wdata_w [3];
    logic [7:0]  dreg_w [3];
    logic [7:0]  sdat [3];
    logic [2:0]  src_re_w, oam_we_w, busy_w, blk_w;
    int checks = 0;
    int failures = 0;
    int blen [3], fre [3], fwe [3], nwe [3], bad [3], ovl [3];
    logic [15:0] fsa [3], lsa [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        oam_dma_ctrl #(.LEN(160), .START_DELAY(g == 0 ? 1 : g == 1 ? 0 : 3)) dut (
            .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_di(cpu_di),
            .src_addr(src_addr_w[g]), .src_re(src_re_w[g]), .src_data(sdat[g]),
            .oam_addr(oam_addr_w[g]), .oam_wdata(oam_wdata_w[g]), .oam_we(oam_we_w[g]),
            .busy(busy_w[g]), .cpu_block(blk_w[g]), .dma_reg(dreg_w[g])
        );
    end

    function automatic logic [7:0] mem(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h9A;
    endfunction

    always_ff @(posedge clk) begin
        for (int k = 0; k < 3; k++) if (src_re_w[k]) sdat[k] <= mem(src_addr_w[k]);
    end

    function automatic int exp_blen(input int k);
        return k == 2 ? 164 : 162;
    endfunction

    function automatic int exp_fre(input int k);
        return k == 2 ? 4 : 2;
    endfunction

    task automatic chk(input string n, input int a, input int e);
        checks++;
        if (a != e) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", n, a, e);
        end
    endtask

    task automatic do_trig(input logic [7:0] v);
        cpu_we = 1'b1;
        cpu_addr = 16'hFF46;
        cpu_di = v;
        @(posedge clk);
        #1;
        cpu_we = 1'b0;
        cpu_addr = 16'h0000;
    endtask

    task automatic watch(input logic [7:0] pg);
        for (int k = 0; k < 3; k++) begin
            blen[k] = 0; fre[k] = 0; fwe[k] = 0; nwe[k] = 0; bad[k] = 0; ovl[k] = 0; fsa[k] = '0; lsa[k] = '0;
        end
        for (int c = 1; c <= 400; c++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                if (busy_w[k]) blen[k]++;
                if (src_re_w[k]) begin
                    if (fre[k] == 0) begin
                        fre[k] = c;
                        fsa[k] = src_addr_w[k];
                    end
                    lsa[k] = src_addr_w[k];
                end
                if (oam_we_w[k]) begin
                    if (fwe[k] == 0) fwe[k] = c;
                    if (oam_addr_w[k] != 8'(nwe[k]) || oam_wdata_w[k] != mem({pg, oam_addr_w[k]})) bad[k]++;
                    nwe[k]++;
                    if (src_re_w[k]) ovl[k]++;
                end
                if (blk_w[k] != (busy_w[k] && fre[k] != 0)) bad[k]++;
            end
            if (busy_w == 3'b000) break;
        end
    endtask

    typedef struct { logic [7:0] di; logic [7:0] pg; } vec_t;
    typedef struct { logic [15:0] a; logic e; } bv_t;
    vec_t vt [7];
    bv_t  bt [6];

    initial begin
        int n;
        vt[0] = '{8'hC0, 8'hC0}; vt[1] = '{8'hFE, 8'hDE}; vt[2] = '{8'h7F, 8'h7F}; vt[3] = '{8'hE0, 8'hC0};
        vt[4] = '{8'hDF, 8'hDF}; vt[5] = '{8'hFF, 8'hDF}; vt[6] = '{8'h00, 8'h00};
        bt[0] = '{16'hFF85, 1'b0}; bt[1] = '{16'hC123, 1'b1}; bt[2] = '{16'hFFFF, 1'b1};
        bt[3] = '{16'hFF80, 1'b0}; bt[4] = '{16'hFFFE, 1'b0}; bt[5] = '{16'hFF7F, 1'b1};

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        cpu_addr = 16'hFFFF;
        #1;
        chk("rst_busy", busy_w, 0);
        chk("rst_src_re", src_re_w, 0);
        chk("rst_oam_we", oam_we_w, 0);
        chk("rst_block", blk_w, 0);
        chk("rst_src_addr", src_addr_w[0], 0);
        chk("rst_oam_addr", oam_addr_w[0], 0);
        chk("rst_oam_wdata", oam_wdata_w[0], 0);
        chk("rst_dma_reg", dreg_w[0], 0);

        cpu_we = 1'b1; cpu_addr = 16'hFF47; cpu_di = 8'h55;
        @(posedge clk); #1;
        cpu_we = 1'b0; cpu_addr = 16'hFF46;
        @(posedge clk); #1;
        cpu_addr = 16'h0000;
        @(negedge clk);
        chk("ignored_busy", busy_w, 0);
        chk("ignored_dma_reg", dreg_w[0], 0);

        for (int i = 0; i < 7; i++) begin
            do_trig(vt[i].di);
            watch(vt[i].pg);
            chk($sformatf("v%0d_dma_reg", i), dreg_w[0], vt[i].di);
            chk($sformatf("v%0d_first_src", i), fsa[0], {vt[i].pg, 8'h00});
            chk($sformatf("v%0d_last_src", i), lsa[0], {vt[i].pg, 8'h9F});
            chk($sformatf("v%0d_src_held", i), src_addr_w[0], {vt[i].pg, 8'h9F});
            chk($sformatf("v%0d_first_we", i), fwe[0], 3);
            chk($sformatf("v%0d_overlap", i), ovl[0], 159);
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("v%0d_d%0d_busy_len", i, k), blen[k], exp_blen(k));
                chk($sformatf("v%0d_d%0d_first_re", i, k), fre[k], exp_fre(k));
                chk($sformatf("v%0d_d%0d_writes", i, k), nwe[k], 160);
                chk($sformatf("v%0d_d%0d_data_or_block_errs", i, k), bad[k], 0);
            end
            chk($sformatf("v%0d_idle_we", i), oam_we_w, 0);
        end

        do_trig(8'hC0);
        cpu_addr = 16'hC123;
        #1;
        chk("blk_start_d1", blk_w[0], 0);
        chk("blk_start_d3", blk_w[2], 0);
        cpu_addr = 16'h0000;
        n = 0;
        while (!src_re_w[0] && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("blk_reach_xfer", src_re_w[0], 1);
        for (int i = 0; i < 6; i++) begin
            cpu_addr = bt[i].a;
            #1;
            chk($sformatf("blk_xfer_%h", bt[i].a), blk_w[0], bt[i].e);
        end
        cpu_addr = 16'h0000;
        n = 0;
        while (busy_w != 3'b000 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("blk_done", busy_w, 0);
        cpu_addr = 16'hFFFF;
        #1;
        chk("blk_idle_ffff", blk_w, 0);
        cpu_addr = 16'hC123;
        #1;
        chk("blk_idle_c123", blk_w, 0);
        cpu_addr = 16'h0000;

        do_trig(8'hC0);
        n = 0;
        for (int c = 0; c < 300 && n < 40; c++) begin
            @(negedge clk);
            if (oam_we_w[0]) n++;
        end
        chk("retrig_pre_writes", n, 40);
        @(posedge clk); #1;
        cpu_we = 1'b1; cpu_addr = 16'hFF46; cpu_di = 8'hD0;
        #1;
        chk("retrig_we_gated", oam_we_w[0], 0);
        @(posedge clk); #1;
        cpu_we = 1'b0; cpu_addr = 16'h0000;
        watch(8'hD0);
        chk("retrig_first_we", fwe[0], 3);
        chk("retrig_first_re", fre[0], 2);
        chk("retrig_first_src", fsa[0], 16'hD000);
        chk("retrig_total_writes", n + nwe[0], 200);
        chk("retrig_errs", bad[0], 0);
        chk("retrig_busy_len", blen[0], 162);
        chk("retrig_dma_reg", dreg_w[0], 8'hD0);

        do_trig(8'hC0);
        repeat (161) @(negedge clk);
        @(posedge clk); #1;
        chk("drain_we", oam_we_w[0], 1);
        chk("drain_addr", oam_addr_w[0], 159);
        cpu_we = 1'b1; cpu_addr = 16'hFF46; cpu_di = 8'hC0;
        #1;
        chk("drain_override_we", oam_we_w[0], 0);
        @(posedge clk); #1;
        cpu_we = 1'b0; cpu_addr = 16'h0000;
        watch(8'hC0);
        chk("drain_re_first_we", fwe[0], 3);
        chk("drain_re_writes", nwe[0], 160);
        chk("drain_re_errs", bad[0], 0);

        do_trig(8'hC0);
        n = 0;
        for (int c = 0; c < 300 && n < 80; c++) begin
            @(negedge clk);
            if (oam_we_w[0]) n++;
        end
        chk("rst_mid_pre_writes", n, 80);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("rst_mid_busy", busy_w, 0);
        chk("rst_mid_src_re", src_re_w, 0);
        chk("rst_mid_oam_we", oam_we_w, 0);
        chk("rst_mid_dma_reg", dreg_w[0], 0);
        @(negedge clk);
        chk("rst_mid_src_re2", src_re_w, 0);
        chk("rst_mid_oam_we2", oam_we_w, 0);
        do_trig(8'hC0);
        watch(8'hC0);
        chk("rst_after_writes", nwe[0], 160);
        chk("rst_after_errs", bad[0], 0);
        chk("rst_after_busy_len", blen[0], 162);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
